// File: rtl/alu_hs.sv
// rtl/alu_hs.sv - registered ALU with valid/ready handshake and iterative multiply
module alu_hs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             ovf
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = SHW + 1;

    localparam logic [3:0] F_CERO = 4'b0000;
    localparam logic [3:0] F_ADD  = 4'b0001;
    localparam logic [3:0] F_SUB  = 4'b0010;
    localparam logic [3:0] F_AND  = 4'b0011;
    localparam logic [3:0] F_OR   = 4'b0100;
    localparam logic [3:0] F_NOT  = 4'b0101;
    localparam logic [3:0] F_XOR  = 4'b0110;
    localparam logic [3:0] F_LSL  = 4'b0111;
    localparam logic [3:0] F_RSL  = 4'b1000;
    localparam logic [3:0] F_MUL  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               accept;
    logic               is_mul;
    logic [WIDTH-1:0]   op_res;
    logic               op_ovf;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   acc_next;
    logic               mul_last;

    assign accept   = in_valid & in_ready;
    assign is_mul   = (funct == F_MUL);
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (count_q == CNT_W'(1));

    // Single-cycle operation result and signed overflow, straight from the input operands
    always_comb begin
        sum    = data1 + data2;
        diff   = data1 - data2;
        op_res = '0;
        op_ovf = 1'b0;
        case (funct)
            F_CERO: op_res = '0;
            F_ADD: begin
                op_res = sum;
                op_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
            end
            F_SUB: begin
                op_res = diff;
                op_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);
            end
            F_AND:   op_res = data1 & data2;
            F_OR:    op_res = data1 | data2;
            F_NOT:   op_res = ~data1;
            F_XOR:   op_res = data1 ^ data2;
            F_LSL:   op_res = data1 << data2[SHW-1:0];
            F_RSL:   op_res = data1 >> data2[SHW-1:0];
            default: op_res = '0;
        endcase
    end

    // Next state: single-cycle ops go straight to DONE, MUL iterates in BUSY
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = is_mul ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (mul_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = is_mul ? S_BUSY : S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; out_ready is the only input reaching in_ready
    always_comb begin
        out_valid = (state_q == S_DONE);
        in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    end

    // Datapath: capture operands/result at accept, shift-and-add one multiplier bit per BUSY cycle
    always_comb begin
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        if (accept) begin
            if (is_mul) begin
                mcand_d  = data1;
                mplier_d = data2;
                acc_d    = '0;
                count_d  = CNT_W'(WIDTH);
            end else begin
                alu_out_d = op_res;
                zero_d    = (op_res == '0);
                ovf_d     = op_ovf;
            end
        end else if (state_q == S_BUSY) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CNT_W'(1);
            if (mul_last) begin
                alu_out_d = acc_next;
                zero_d    = (acc_next == '0);
                ovf_d     = 1'b0;
            end
        end
    end

    // State and datapath registers; reset abandons any in-flight multiply
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            alu_out_q <= '0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
        end
    end

    assign alu_out = alu_out_q;
    assign zero    = zero_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_alu_hs.sv
// tb/tb_alu_hs.sv - directed vector bench for alu_hs
module tb_alu_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  funct;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic        zero;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_zero;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [14];

    alu_hs #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct    (funct),
        .data1    (data1),
        .data2    (data2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_out  (alu_out),
        .zero     (zero),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // entered at a negedge; returns 1 after the accept edge with operands scrambled
    task automatic start_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        funct    = f;
        data1    = a;
        data2    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        funct    = 4'b0101;
        data1    = ~a;
        data2    = ~b;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
        start_op(v.f, v.a, v.b);
        @(negedge clk);
        check($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, 32'd1);
        check($sformatf("v%0d alu_out", idx), alu_out, v.exp_out);
        check($sformatf("v%0d zero", idx), {31'd0, zero}, {31'd0, v.exp_zero});
        check($sformatf("v%0d ovf", idx), {31'd0, ovf}, {31'd0, v.exp_ovf});
        @(negedge clk);
    endtask

    // counts edges after the accept edge until out_valid, checking in_ready stays low meanwhile
    task automatic wait_mul(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            check($sformatf("mul busy in_ready e%0d", lat), {31'd0, in_ready}, 32'd0);
        end
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input string name);
        int lat;
        start_op(4'b1001, a, b);
        wait_mul(lat);
        check({name, " latency"}, lat, 32);
        check({name, " alu_out"}, alu_out, exp);
        check({name, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
        check({name, " ovf"}, {31'd0, ovf}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        funct     = 4'd0;
        data1     = 32'd0;
        data2     = 32'd0;
        out_ready = 1'b1;

        vecs[0]  = '{4'b0001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[1]  = '{4'b0010, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{4'b1111, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[3]  = '{4'b0111, 32'h00000001, 32'd31,       32'h80000000, 1'b0, 1'b0};
        vecs[4]  = '{4'b1000, 32'h80000000, 32'd36,       32'h08000000, 1'b0, 1'b0};
        vecs[5]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[7]  = '{4'b0100, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0};
        vecs[8]  = '{4'b0101, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{4'b0110, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1'b0};
        vecs[10] = '{4'b0010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[11] = '{4'b0001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[12] = '{4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
        vecs[13] = '{4'b0010, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst alu_out", alu_out, 32'd0);
        check("rst zero", {31'd0, zero}, 32'd1);
        check("rst ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            apply_vec(vecs[i], i);
        end

        // MUL with the consumer stalled, then a back-to-back accept out of DONE
        out_ready = 1'b0;
        start_op(4'b1001, 32'h0000FFFF, 32'h00010001);
        wait_mul(lat);
        check("mul latency", lat, 32);
        check("mul alu_out", alu_out, 32'hFFFFFFFF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("stall%0d alu_out", k), alu_out, 32'hFFFFFFFF);
            check($sformatf("stall%0d zero", k), {31'd0, zero}, 32'd0);
        end
        out_ready = 1'b1;
        funct     = 4'b0011;
        data1     = 32'hF0F0F0F0;
        data2     = 32'hFF00FF00;
        in_valid  = 1'b1;
        #1;
        check("b2b in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b out_valid", {31'd0, out_valid}, 32'd1);
        check("b2b alu_out", alu_out, 32'hF000F000);
        check("b2b zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        check("b2b drain out_valid", {31'd0, out_valid}, 32'd0);

        run_mul(32'h12345678, 32'h00000009, 32'hA3D70A38, "mul2");
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul3");
        run_mul(32'h00001234, 32'h00000000, 32'h00000000, "mul4");

        // reset on the 10th cycle of a MUL
        start_op(4'b1001, 32'h00000003, 32'h00000005);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort alu_out", alu_out, 32'd0);
        check("abort zero", {31'd0, zero}, 32'd1);
        check("abort ovf", {31'd0, ovf}, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("abort no result", seen, 0);
        @(negedge clk);
        apply_vec('{4'b0001, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0}, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_hs.md
# alu_hs

Parametrised, registered ALU with a valid/ready handshake on both sides. It keeps the datapath funct encoding and adds logical shifts, an iterative multiply and a signed-overflow flag. It sits between decode/operand fetch and writeback. It is the drop-in successor to the combinational ALU for pipelines that must stall on multi-cycle operations.

## Interface
- WIDTH, 32, operand and result width; must be ≥ 2 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the operation on funct/data1/data2 is valid.
- in_ready  out  1  the block accepts an operation this cycle.
- funct  in  4  operation code.
- data1  in  WIDTH  operand A.
- data2  in  WIDTH  operand B; for shifts, only data2[SHW-1:0] is used.
- out_valid  out  1  alu_out, zero and ovf are valid.
- out_ready  in  1  the consumer takes the result this cycle.
- alu_out  out  WIDTH  registered result.
- zero  out  1  registered; 1 when alu_out == 0.
- ovf  out  1  registered signed overflow for ADD/SUB, 0 for every other op.

## Operation
- funct codes:
  - 0000 CERO → 0.
  - 0001 ADD → A+B.
  - 0010 SUB → A−B.
  - 0011 AND.
  - 0100 OR.
  - 0101 NOT → ~A.
  - 0110 XOR.
  - 0111 LSL → A << B[SHW-1:0].
  - 1000 RSL → A >> B[SHW-1:0], logical, zero-fill.
  - 1001 MUL → low WIDTH bits of A×B, unsigned.
  - 1010–1111 → 0.
- Arithmetic is modulo 2^WIDTH; carry-out is discarded.
- ovf for ADD: sign(A) == sign(B) and sign(result) ≠ sign(A).
- ovf for SUB: sign(A) ≠ sign(B) and sign(result) ≠ sign(A).
- Operands and funct are captured at accept. Input changes after accept have no effect.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. On accept of a non-MUL op, the result is registered and the state goes to DONE. On accept of MUL, the operands are latched, the accumulator is cleared, count = WIDTH, and the state goes to BUSY.
  - BUSY: in_ready = 0. Each cycle, if multiplier bit 0 is set, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and decrement count. When count reaches 1, register the final accumulator value and go to DONE.
  - DONE: out_valid = 1; outputs are held stable until the result is taken. If out_ready = 1 and in_valid = 0, go to IDLE. If out_ready = 1 and in_valid = 1, accept the new op in the same cycle and take the same path as IDLE. If out_ready = 0, stay.
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- zero and ovf are registered together with alu_out, from the same op.
- Reset values: state IDLE, out_valid 0, alu_out 0, zero 1, ovf 0. MUL datapath registers clear to 0.
- Reset in any state, including mid-MUL, aborts the op. The aborted result is never presented.

## Timing
- Accept = in_valid & in_ready at a rising edge.
- Non-MUL latency: result and out_valid appear on the first edge after accept. Throughput is 1 op/cycle when out_ready is held at 1.
- MUL latency: out_valid rises on the WIDTH-th edge after the accept edge. in_ready is low in every cycle between.
- Output transfer = out_valid & out_ready at a rising edge.
- out_valid never drops without a transfer or reset.
- No combinational path from in_valid/funct/data to the outputs.
- Combinational paths: only out_ready → in_ready.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 → next cycle: alu_out 0x80000000, ovf 1, zero 0, out_valid 1.
- SUB 0x00000005 − 0x00000005 → 0x00000000, zero 1, ovf 0. Then funct 1111 → 0x00000000, zero 1.
- LSL 0x00000001 by data2 = 31 → 0x80000000. RSL 0x80000000 by data2 = 36 (uses 4) → 0x08000000. Each takes 1 cycle.
- MUL 0x0000FFFF × 0x00010001:
  - in_ready low for 31 cycles after accept.
  - out_valid rises 32 edges after accept with 0xFFFFFFFF.
  - With out_ready held at 0 for 5 cycles, outputs stay stable and in_ready stays 0.
- Back-to-back in DONE: out_ready = 1 and in_valid = 1 with AND 0xF0F0F0F0 & 0xFF00FF00.
  - The next edge transfers the old result and accepts the new op.
  - out_valid stays 1 and alu_out becomes 0xF000F000.
- Assert rst on the 10th cycle of a MUL → next cycle: out_valid 0, alu_out 0, zero 1, ovf 0, in_ready 1. A following ADD 2 + 3 returns 0x00000005 normally.
